ahb_burst_master: RTL and testbench
===================================

Name: ahb_burst_master

Overview:
- Synthesizable, parametrised AHB-Lite master. Successor to the task-driven single-transfer master.
- Accepts transfer commands on a valid/ready interface and issues SINGLE, INCR and INCR4/8/16 bursts.
- Handles pipelined address/data phases, slave wait states and two-cycle ERROR responses.
- Sits between a local command source (DMA/test sequencer) and the AHB-to-APB bridge slave port.

Parameters:
DATA_W, 32, AHB data bus width in bits (32 or 64).
ADDR_W, 32, AHB address width in bits.
LEN_W, 5, width of cmd_len; max INCR length is 2^LEN_W-1 beats.

Ports:
Hclk  in  1  bus clock, rising edge.
Hresetn  in  1  asynchronous active-low reset.
Hreadyout  in  1  slave ready; 1 = current data phase completes this edge.
Hresp  in  2  slave response; 00 OKAY, 01 ERROR.
Hrdata  in  DATA_W  read data.
Hwrite  out  1  1 = write transfer.
Hreadyin  out  1  HREADY fed to slave.
Htrans  out  2  00 IDLE, 10 NONSEQ, 11 SEQ (01 BUSY never driven).
Haddr  out  ADDR_W  transfer address.
Hwdata  out  DATA_W  write data.
Hburst  out  3  burst type of current transfer.
Hsize  out  3  transfer size.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
cmd_write  in  1  1 = write.
cmd_addr  in  ADDR_W  start address.
cmd_burst  in  3  000 SINGLE, 001 INCR, 011 INCR4, 101 INCR8, 111 INCR16.
cmd_len  in  LEN_W  beat count, used only for INCR (0 treated as 1).
cmd_size  in  3  bytes per beat = 2^cmd_size.
wr_data  in  DATA_W  next write beat; sampled when wr_req = 1.
wr_req  out  1  pulse; wr_data consumed this edge.
rd_data  out  DATA_W  captured read beat.
rd_valid  out  1  pulse; rd_data valid.
done  out  1  one-cycle pulse; command finished with OKAY.
err  out  1  one-cycle pulse; command aborted or rejected.

Behaviour:
- Reset (asynchronous, immediate, also mid-burst): Htrans=00, Hwrite=0, Haddr=0, Hwdata=0, Hburst=0, Hsize=0, Hreadyin=0, wr_req=0, rd_data=0, rd_valid=0, done=0, err=0, state=IDLE.
- Hreadyin is a registered 1 from the first edge after reset release.
- cmd_ready = (state==IDLE), combinational.
- States:
  - IDLE: on accept -> ADDR.
  - ADDR: drives NONSEQ.
  - BURST: drives SEQ.
  - LAST: final data phase, Htrans=IDLE.
  - ERR: second ERROR cycle.
- Command validity: a command is illegal if cmd_burst is 010, 100 or 110, or if 2^cmd_size > DATA_W/8. An illegal command is accepted, err pulses the next cycle, no bus activity, and the block stays IDLE.
- Accept at edge T. From T+1: Htrans=NONSEQ, Haddr=cmd_addr, Hwrite, Hburst and Hsize are driven.
- An address phase completes on an edge with Hreadyout=1. The next address is Haddr + 2^Hsize with Htrans=SEQ, until all beats have issued. Beats = 1, cmd_len, 4, 8 or 16 by burst type.
- After the last address completes: Htrans=IDLE, state LAST.
- 1KB boundary (INCR only): when the next address crosses a 1KB boundary, it is issued as NONSEQ instead of SEQ. The beat count continues. INCR4/8/16 that would cross the boundary are illegal and rejected as above.
- Write data:
  - wr_req pulses on each edge where an address phase completes for a write.
  - wr_data is registered into Hwdata at that edge, i.e. it is valid for the matching data phase.
  - Hwdata holds during wait states.
- Read data: on a data-phase edge with Hreadyout=1 and Hresp=00, rd_data<=Hrdata and rd_valid pulses on the following cycle.
- Wait states: while Hreadyout=0, Haddr, Htrans, Hwrite, Hburst, Hsize and Hwdata hold unchanged.
- ERROR handling:
  - First ERROR cycle (Hresp=01, Hreadyout=0): Htrans=IDLE on the next cycle, remaining beats cancelled, state ERR.
  - Second cycle (Hresp=01, Hreadyout=1): err pulses and the block returns to IDLE.
  - rd_valid is not asserted for an errored beat.
- done pulses one cycle after the final data phase completes OKAY. done and err are never both asserted for one command.
- A new command is accepted no earlier than the cycle done/err is asserted. There is no back-to-back address overlap between commands.

Test Plan:
- SINGLE write, addr 0x8000_0001, size 0, wr_data 0xA3, Hreadyout=1 -> NONSEQ at T+1, wr_req at T+2, Hwdata=0xA3 at T+2, done at T+3.
- INCR4 read, addr 0x8000_00A0, size 2, slave returns 0x11,0x22,0x33,0x44 -> addresses A0,A4,A8,AC with NONSEQ,SEQ,SEQ,SEQ; four rd_valid pulses in order; one done pulse.
- INCR8 write with Hreadyout=0 for 2 cycles on beat 3 -> bus signals frozen for 2 cycles, 8 wr_req total, done once.
- INCR, len 6, size 2, addr 0x0000_03F8 -> beat 3 at 0x400 issued NONSEQ, 6 beats total, done.
- INCR16 read with ERROR on beat 5 -> Htrans=IDLE after first ERROR cycle, err pulse, 4 rd_valid pulses, no done, cmd_ready high again.
- Illegal commands: cmd_burst=010, or cmd_size=3 with DATA_W=32 -> err only, Htrans stays 00. Hresetn low mid-INCR8 -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ahb_burst_master_if.sv
// Bus and command bundle for ahb_burst_master.
// The master modport is the burst engine's view.
interface ahb_burst_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 5
);
  logic              Hreadyout;
  logic [1:0]        Hresp;
  logic [DATA_W-1:0] Hrdata;
  logic              Hwrite;
  logic              Hreadyin;
  logic [1:0]        Htrans;
  logic [ADDR_W-1:0] Haddr;
  logic [DATA_W-1:0] Hwdata;
  logic [2:0]        Hburst;
  logic [2:0]        Hsize;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0]        cmd_burst;
  logic [LEN_W-1:0]  cmd_len;
  logic [2:0]        cmd_size;
  logic [DATA_W-1:0] wr_data;
  logic              wr_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              done;
  logic              err;

  modport master (
    input  Hreadyout, Hresp, Hrdata,
    input  cmd_valid, cmd_write, cmd_addr,
    input  cmd_burst, cmd_len, cmd_size,
    input  wr_data,
    output Hwrite, Hreadyin, Htrans, Haddr,
    output Hwdata, Hburst, Hsize,
    output cmd_ready, wr_req, rd_data,
    output rd_valid, done, err
  );

  modport slave (
    output Hreadyout, Hresp, Hrdata,
    output cmd_valid, cmd_write, cmd_addr,
    output cmd_burst, cmd_len, cmd_size,
    output wr_data,
    input  Hwrite, Hreadyin, Htrans, Haddr,
    input  Hwdata, Hburst, Hsize,
    input  cmd_ready, wr_req, rd_data,
    input  rd_valid, done, err
  );
endinterface

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: SINGLE/INCR/INCR4/8/16
// with wait states and two-cycle ERROR abort.
module ahb_burst_master #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 5
) (
  input logic Hclk,
  input logic Hresetn,
  ahb_burst_master_if.master bus
);

  localparam int CNT_W = (LEN_W > 5) ? LEN_W : 5;
  localparam logic [2:0] SIZE_MAX =
    3'($clog2(DATA_W / 8));
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [1:0] R_ERR    = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hburst_q, hburst_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [CNT_W-1:0]  left_q, left_d;
  logic              dph_q, dph_d;
  logic              wreq_q, wreq_d;
  logic              rvld_q, rvld_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hready_q;

  logic [CNT_W-1:0]  cmd_left;
  logic [15:0]       fix_beats;
  logic [15:0]       span;
  logic              burst_ok;
  logic              cmd_bad;
  logic [ADDR_W-1:0] addr_inc;
  logic              cross_1k;
  logic              abort;

  always_comb begin
    cmd_left  = '0;
    fix_beats = '0;
    burst_ok  = 1'b1;
    unique case (bus.cmd_burst)
      3'b000: cmd_left = '0;
      3'b001: cmd_left = (bus.cmd_len == '0) ? '0 :
                CNT_W'(bus.cmd_len) - CNT_W'(1);
      3'b011: begin
        cmd_left  = CNT_W'(3);
        fix_beats = 16'd4;
      end
      3'b101: begin
        cmd_left  = CNT_W'(7);
        fix_beats = 16'd8;
      end
      3'b111: begin
        cmd_left  = CNT_W'(15);
        fix_beats = 16'd16;
      end
      default: burst_ok = 1'b0;
    endcase
  end

  // Wrapping-free fixed bursts must fit inside one 1KB page.
  assign span = fix_beats << bus.cmd_size;
  assign cmd_bad = !burst_ok
    || (bus.cmd_size > SIZE_MAX)
    || (({6'b0, bus.cmd_addr[9:0]} + span)
        > 16'd1024);

  assign addr_inc = haddr_q + (ADDR_W'(1) << hsize_q);
  assign cross_1k =
    addr_inc[ADDR_W-1:10] != haddr_q[ADDR_W-1:10];
  assign abort = dph_q && (bus.Hresp == R_ERR);

  always_comb begin
    state_d  = state_q;
    htrans_d = htrans_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    hwrite_d = hwrite_q;
    hburst_d = hburst_q;
    hsize_d  = hsize_q;
    left_d   = left_q;
    dph_d    = dph_q;
    wreq_d   = 1'b0;
    rvld_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (dph_q && bus.Hreadyout && !hwrite_q
        && bus.Hresp == 2'b00) begin
      rdata_d = bus.Hrdata;
      rvld_d  = 1'b1;
    end

    if (abort) begin
      htrans_d = T_IDLE;
      dph_d    = 1'b0;
      if (bus.Hreadyout) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        state_d = S_ERR;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid && cmd_bad) begin
            err_d = 1'b1;
          end else if (bus.cmd_valid) begin
            state_d  = S_ADDR;
            htrans_d = T_NONSEQ;
            haddr_d  = bus.cmd_addr;
            hwrite_d = bus.cmd_write;
            hburst_d = bus.cmd_burst;
            hsize_d  = bus.cmd_size;
            left_d   = cmd_left;
            dph_d    = 1'b0;
          end
        end
        S_ADDR, S_BURST: begin
          if (bus.Hreadyout) begin
            dph_d = 1'b1;
            if (hwrite_q) begin
              wreq_d   = 1'b1;
              hwdata_d = bus.wr_data;
            end
            if (left_q != '0) begin
              left_d   = left_q - CNT_W'(1);
              haddr_d  = addr_inc;
              htrans_d = cross_1k ? T_NONSEQ : T_SEQ;
              state_d  = S_BURST;
            end else begin
              htrans_d = T_IDLE;
              state_d  = S_LAST;
            end
          end
        end
        S_LAST: begin
          if (bus.Hreadyout) begin
            done_d  = 1'b1;
            dph_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
        S_ERR: begin
          if (bus.Hreadyout) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q  <= S_IDLE;
      htrans_q <= T_IDLE;
      haddr_q  <= '0;
      hwdata_q <= '0;
      rdata_q  <= '0;
      hwrite_q <= 1'b0;
      hburst_q <= '0;
      hsize_q  <= '0;
      left_q   <= '0;
      dph_q    <= 1'b0;
      wreq_q   <= 1'b0;
      rvld_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      hready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      htrans_q <= htrans_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      hwrite_q <= hwrite_d;
      hburst_q <= hburst_d;
      hsize_q  <= hsize_d;
      left_q   <= left_d;
      dph_q    <= dph_d;
      wreq_q   <= wreq_d;
      rvld_q   <= rvld_d;
      done_q   <= done_d;
      err_q    <= err_d;
      hready_q <= 1'b1;
    end
  end

  assign bus.Htrans    = htrans_q;
  assign bus.Haddr     = haddr_q;
  assign bus.Hwdata    = hwdata_q;
  assign bus.Hwrite    = hwrite_q;
  assign bus.Hburst    = hburst_q;
  assign bus.Hsize     = hsize_q;
  assign bus.Hreadyin  = hready_q;
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.wr_req    = wreq_q;
  assign bus.rd_data   = rdata_q;
  assign bus.rd_valid  = rvld_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed vector bench for ahb_burst_master.
// Table of per-edge vectors plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_ahb_burst_master;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LW = 5;

  logic Hclk;
  logic Hresetn;
  int   nvec;
  int   nbad;

  ahb_burst_master_if #(
    .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)
  ) bus ();

  ahb_burst_master #(
    .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)
  ) dut (
    .Hclk(Hclk),
    .Hresetn(Hresetn),
    .bus(bus)
  );

  initial begin
    Hclk = 1'b0;
    forever #5 Hclk = ~Hclk;
  end

  typedef struct {
    logic        vld;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  burst;
    logic [4:0]  len;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [1:0]  e_trans;
    logic [31:0] e_addr;
    logic        e_wreq;
    logic [31:0] e_wdata;
    logic        e_rv;
    logic [31:0] e_rdata;
    logic        e_done;
    logic        e_err;
    logic        e_crdy;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  task automatic chk_reset(input string nm);
    chk(nm, 256'({bus.Htrans, bus.Haddr,
                  bus.Hwdata, bus.Hwrite,
                  bus.Hburst, bus.Hsize,
                  bus.Hreadyin, bus.wr_req,
                  bus.rd_data, bus.rd_valid,
                  bus.done, bus.err,
                  bus.cmd_ready}),
        256'd1);
  endtask

  task automatic send(input logic wr,
                      input logic [31:0] addr,
                      input logic [2:0] burst,
                      input logic [4:0] len,
                      input logic [2:0] size);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_burst = burst;
    bus.cmd_len   = len;
    bus.cmd_size  = size;
  endtask

  initial begin
    logic [65:0] snap;
    int wn, dn, dk, rn;

    nvec = 0;
    nbad = 0;
    bus.Hreadyout = 1'b1;
    bus.Hresp     = 2'b00;
    bus.Hrdata    = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_burst = '0;
    bus.cmd_len   = '0;
    bus.cmd_size  = '0;
    bus.wr_data   = '0;

    Hresetn = 1'b1;
    #2 Hresetn = 1'b0;
    #3 chk_reset("reset_state");
    #14 Hresetn = 1'b1;
    step();
    chk("hreadyin_up",
        256'({bus.Hreadyin, bus.Htrans}),
        256'(3'b100));

    // SINGLE write
    vt[0]  = '{1,1,32'h8000_0001,3'b000,5'd0,3'd0,32'hA3,
               1,2'b00,32'h0,
               2'b10,32'h8000_0001,0,32'h0,0,32'h0,0,0,0};
    vt[1]  = '{0,1,32'h8000_0001,3'b000,5'd0,3'd0,32'hA3,
               1,2'b00,32'h0,
               2'b00,32'h8000_0001,1,32'hA3,0,32'h0,0,0,0};
    vt[2]  = '{0,0,32'h0,3'b000,5'd0,3'd0,32'h0,
               1,2'b00,32'h0,
               2'b00,32'h8000_0001,0,32'hA3,0,32'h0,1,0,1};
    vt[3]  = '{0,0,32'h0,3'b000,5'd0,3'd0,32'h0,
               1,2'b00,32'h0,
               2'b00,32'h8000_0001,0,32'hA3,0,32'h0,0,0,1};
    // INCR4 read
    vt[4]  = '{1,0,32'h8000_00A0,3'b011,5'd0,3'd2,32'h0,
               1,2'b00,32'h0,
               2'b10,32'h8000_00A0,0,32'hA3,0,32'h0,0,0,0};
    vt[5]  = '{0,0,32'h0,3'b000,5'd0,3'd0,32'h0,
               1,2'b00,32'h0,
               2'b11,32'h8000_00A4,0,32'hA3,0,32'h0,0,0,0};
    vt[6]  = '{0,0,32'h0,3'b000,5'd0,3'd0,32'h0,
               1,2'b00,32'h11,
               2'b11,32'h8000_00A8,0,32'hA3,1,32'h11,0,0,0};
    vt[7]  = '{0,0,32'h0,3'b000,5'd0,3'd0,32'h0,
               1,2'b00,32'h22,
               2'b11,32'h8000_00AC,0,32'hA3,1,32'h22,0,0,0};
    vt[8]  = '{0,0,32'h0,3'b000,5'd0,3'd0,32'h0,
               1,2'b00,32'h33,
               2'b00,32'h8000_00AC,0,32'hA3,1,32'h33,0,0,0};
    vt[9]  = '{0,0,32'h0,3'b000,5'd0,3'd0,32'h0,
               1,2'b00,32'h44,
               2'b00,32'h8000_00AC,0,32'hA3,1,32'h44,1,0,1};
    vt[10] = '{0,0,32'h0,3'b000,5'd0,3'd0,32'h0,
               1,2'b00,32'h0,
               2'b00,32'h8000_00AC,0,32'hA3,0,32'h44,0,0,1};
    // illegal: reserved burst, oversize, INCR8 over 1KB
    vt[11] = '{1,1,32'h100,3'b010,5'd0,3'd2,32'h0,
               1,2'b00,32'h0,
               2'b00,32'h8000_00AC,0,32'hA3,0,32'h44,0,1,1};
    vt[12] = '{1,0,32'h200,3'b000,5'd0,3'd3,32'h0,
               1,2'b00,32'h0,
               2'b00,32'h8000_00AC,0,32'hA3,0,32'h44,0,1,1};
    vt[13] = '{0,0,32'h0,3'b000,5'd0,3'd0,32'h0,
               1,2'b00,32'h0,
               2'b00,32'h8000_00AC,0,32'hA3,0,32'h44,0,0,1};
    vt[14] = '{1,0,32'h3F0,3'b101,5'd0,3'd2,32'h0,
               1,2'b00,32'h0,
               2'b00,32'h8000_00AC,0,32'hA3,0,32'h44,0,1,1};
    vt[15] = '{0,0,32'h0,3'b000,5'd0,3'd0,32'h0,
               1,2'b00,32'h0,
               2'b00,32'h8000_00AC,0,32'hA3,0,32'h44,0,0,1};

    for (int i = 0; i < 16; i++) begin
      bus.cmd_valid = vt[i].vld;
      bus.cmd_write = vt[i].wr;
      bus.cmd_addr  = vt[i].addr;
      bus.cmd_burst = vt[i].burst;
      bus.cmd_len   = vt[i].len;
      bus.cmd_size  = vt[i].size;
      bus.wr_data   = vt[i].wdata;
      bus.Hreadyout = vt[i].rdy;
      bus.Hresp     = vt[i].resp;
      bus.Hrdata    = vt[i].rdata;
      step();
      chk($sformatf("vec%0d", i),
          256'({bus.Htrans, bus.Haddr, bus.wr_req,
                bus.Hwdata, bus.rd_valid,
                bus.rd_data, bus.done, bus.err,
                bus.cmd_ready}),
          256'({vt[i].e_trans, vt[i].e_addr,
                vt[i].e_wreq, vt[i].e_wdata,
                vt[i].e_rv, vt[i].e_rdata,
                vt[i].e_done, vt[i].e_err,
                vt[i].e_crdy}));
    end

    // INCR8 write, 2 wait states on beat 3 data phase
    bus.Hreadyout = 1'b1;
    bus.Hresp     = 2'b00;
    bus.wr_data   = 32'hD0;
    send(1'b1, 32'h2000_0000, 3'b101, 5'd0, 3'd2);
    step();
    bus.cmd_valid = 1'b0;
    chk("incr8_first",
        256'({bus.Htrans, bus.Haddr, bus.Hburst,
              bus.Hsize, bus.Hwrite}),
        256'({2'b10, 32'h2000_0000, 3'b101,
              3'd2, 1'b1}));
    wn = 0; dn = 0; dk = 0; snap = '0;
    for (int k = 1; k <= 30; k++) begin
      bus.Hreadyout = (k == 4 || k == 5) ? 1'b0 : 1'b1;
      step();
      if (k == 3) begin
        snap = {bus.Htrans, bus.Haddr, bus.Hwdata};
        chk("incr8_beat4_addr",
            256'({bus.Htrans, bus.Haddr}),
            256'({2'b11, 32'h2000_000C}));
      end
      if (k == 4 || k == 5)
        chk("incr8_frozen",
            256'({bus.Htrans, bus.Haddr,
                  bus.Hwdata, bus.wr_req}),
            256'({snap, 1'b0}));
      if (bus.wr_req) begin
        chk("incr8_hwdata", 256'(bus.Hwdata),
            256'(32'(32'hD0 + wn)));
        wn++;
        bus.wr_data = 32'(32'hD0 + wn);
      end
      if (bus.done) begin
        dn++;
        if (dk == 0) dk = k;
      end
    end
    chk("incr8_wr_reqs", 256'(wn), 256'(8));
    chk("incr8_done_cnt", 256'(dn), 256'(1));
    chk("incr8_done_cycle", 256'(dk), 256'(11));

    // INCR len 6 crossing 1KB at 0x400
    send(1'b0, 32'h0000_03F8, 3'b001, 5'd6, 3'd2);
    bus.Hrdata = 32'h55;
    step();
    bus.cmd_valid = 1'b0;
    chk("incr_b0",
        256'({bus.Htrans, bus.Haddr}),
        256'({2'b10, 32'h0000_03F8}));
    rn = 0; dk = 0; dn = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 2)
        chk("incr_1k_nonseq",
            256'({bus.Htrans, bus.Haddr}),
            256'({2'b10, 32'h0000_0400}));
      else if (k <= 5)
        chk($sformatf("incr_b%0d", k),
            256'({bus.Htrans, bus.Haddr}),
            256'({2'b11, 32'(32'h3F8 + 4 * k)}));
      if (k == 6)
        chk("incr_last_idle", 256'(bus.Htrans),
            256'(2'b00));
      if (bus.rd_valid) rn++;
      if (bus.done) begin
        dn++;
        dk = k;
      end
    end
    chk("incr_rd_cnt", 256'(rn), 256'(6));
    chk("incr_done_cycle",
        256'({dn, dk}), 256'({32'd1, 32'd7}));

    // INCR16 read, ERROR on beat 5
    send(1'b0, 32'h4000_0000, 3'b111, 5'd0, 3'd2);
    step();
    bus.cmd_valid = 1'b0;
    rn = 0; dn = 0;
    for (int k = 1; k <= 12; k++) begin
      bus.Hreadyout = (k == 6) ? 1'b0 : 1'b1;
      bus.Hresp = (k == 6 || k == 7) ? 2'b01 : 2'b00;
      bus.Hrdata = 32'(32'hB0 + k - 1);
      step();
      if (k == 5)
        chk("err_beat6_addr",
            256'({bus.Htrans, bus.Haddr}),
            256'({2'b11, 32'h4000_0014}));
      if (k == 6)
        chk("err_idle", 256'({bus.Htrans, bus.err}),
            256'(3'b000));
      if (k == 7)
        chk("err_pulse",
            256'({bus.err, bus.cmd_ready, bus.Htrans}),
            256'(4'b1100));
      if (k == 8)
        chk("err_one_cycle", 256'(bus.err), 256'(0));
      if (bus.rd_valid) begin
        rn++;
        chk("err_rdata", 256'(bus.rd_data),
            256'(32'(32'hB0 + rn)));
      end
      if (bus.done) dn++;
    end
    chk("err_rd_cnt", 256'(rn), 256'(4));
    chk("err_no_done", 256'(dn), 256'(0));

    // asynchronous reset in the middle of INCR8
    bus.Hresp = 2'b00;
    bus.wr_data = 32'hE0;
    send(1'b1, 32'h5000_0000, 3'b101, 5'd0, 3'd2);
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    #2 Hresetn = 1'b0;
    #1 chk_reset("reset_mid_burst");
    #3 Hresetn = 1'b1;
    step();
    chk("reset_release",
        256'({bus.Hreadyin, bus.Htrans,
              bus.cmd_ready}),
        256'(4'b1001));

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end
endmodule
